slave_serial_port: RTL and testbench
====================================

SLAVE_SERIAL_PORT -- requirements
Module: slave_serial_port

Interface
REQ-001 Parameter ADDR_LEN, default 12, memory address width in bits.
REQ-002 Parameter DATA_LEN, default 8, data word width in bits.
REQ-003 Parameter BURST_LEN, default 12, burst-count width in bits.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and rst.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 read_en  input  1  bus read request, held for the whole transaction.
REQ-008 write_en  input  1  bus write request, held for the whole transaction.
REQ-009 master_valid  input  1  the master is driving a valid bit on rx_address, rx_burst or rx_data this cycle.
REQ-010 master_ready  input  1  the master accepts a tx_data bit this cycle.
REQ-011 rx_address  input  1  serial address, LSB first.
REQ-012 rx_burst  input  1  serial burst count, LSB first, shifted concurrently with the first BURST_LEN address bits.
REQ-013 rx_data  input  1  serial write data, LSB first.
REQ-014 slave_ready  output  1  port can accept serial input bits.
REQ-015 slave_valid  output  1  tx_data carries a valid read-data bit.
REQ-016 tx_data  output  1  serial read data, LSB first.
REQ-017 mem_addr  output  ADDR_LEN  memory word address.
REQ-018 mem_wdata  output  DATA_LEN  memory write data.
REQ-019 mem_we  output  1  single-cycle memory write strobe.
REQ-020 mem_re  output  1  single-cycle memory read strobe.
REQ-021 mem_rdata  input  DATA_LEN  memory read data, valid one cycle after mem_re.

Function
REQ-022 The FSM SHALL use the states IDLE, RX_ADDR, RX_WDATA, WRITE, READ, READ_WAIT, TX_RDATA.
REQ-023 IDLE: slave_ready=1; when exactly one of read_en/write_en is 1 and master_valid=1, capture bit 0 of address and burst and go to RX_ADDR; if both or neither are 1, stay in IDLE.
REQ-024 Serial shifting SHALL advance only on cycles with master_valid=1; a deasserted master_valid stalls the bit counter without losing captured bits.
REQ-025 RX_ADDR: slave_ready=1; after ADDR_LEN total bits, load mem_addr, then go to RX_WDATA if write_en=1 or to READ if read_en=1.
REQ-026 Burst count N SHALL give N beats; N=0 SHALL be treated as 1 beat.
REQ-027 RX_WDATA: slave_ready=1; after DATA_LEN bits, load mem_wdata and go to WRITE.
REQ-028 WRITE: mem_we=1 for exactly one cycle and beats_left decrements; if beats remain, increment mem_addr and go to RX_WDATA, else go to IDLE.
REQ-029 READ: mem_re=1 for one cycle, then READ_WAIT; READ_WAIT latches mem_rdata into the tx shift register and goes to TX_RDATA.
REQ-030 TX_RDATA: slave_valid=1, slave_ready=0, tx_data = current LSB; shift only on master_ready=1.
REQ-031 After DATA_LEN accepted bits in TX_RDATA: if beats remain, increment mem_addr and go to READ, else go to IDLE with slave_valid=0.
REQ-032 Address increment SHALL wrap modulo 2^ADDR_LEN (4095 to 0 at default width).
REQ-033 If read_en and write_en both drop to 0 in any non-IDLE state, the FSM SHALL return to IDLE next cycle with no memory strobe issued.
REQ-034 mem_we and mem_re SHALL never be 1 in the same cycle.

Reset
REQ-035 On rst=0 the FSM SHALL enter IDLE asynchronously, including mid-transaction.
REQ-036 Reset values: slave_ready=1, slave_valid=0, tx_data=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, all counters and shift registers 0.

Structure
REQ-037 ADDR_LEN, DATA_LEN, BURST_LEN and the state encodings SHALL live in the shared bus definitions header also used by the master and interconnect.
REQ-038 One sub-module, serial_shift_reg (parameterised width, shift-enable, parallel load/out), SHALL be instantiated for address, burst, write-data and read-data.

Verification
REQ-039 Single write: write_en=1, address 0x123, burst 1, data 0xA5 -> one mem_we pulse with mem_addr=0x123 and mem_wdata=0xA5, then IDLE.
REQ-040 Burst read: read_en=1, address 0x010, burst 3, memory 0x11/0x22/0x33 -> tx_data streams 0x11, 0x22, 0x33 LSB first with slave_valid high, and mem_re is issued at addresses 0x010 to 0x012.
REQ-041 Wrap: write burst 2 at 0xFFF -> mem_we at 0xFFF then at 0x000.
REQ-042 Stalls: master_valid toggling 1/0 during the address phase, and master_ready low for 3 cycles mid-byte -> captured address and tx bit order are unchanged.
REQ-043 Reset mid-burst: rst=0 during TX_RDATA -> slave_valid=0 and slave_ready=1 immediately, with no further mem_re.
REQ-044 Illegal request: read_en=write_en=1 in IDLE -> FSM stays in IDLE and no strobes are issued.

Source files
------------

// File: rtl/slave_serial_port_pkg.sv
// Shared serial-bus definitions: default field widths and slave port FSM states.
package slave_serial_port_pkg;

    localparam int unsigned SSP_ADDR_LEN  = 12;
    localparam int unsigned SSP_DATA_LEN  = 8;
    localparam int unsigned SSP_BURST_LEN = 12;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_ADDR    = 3'd1,
        RX_WDATA   = 3'd2,
        WRITE      = 3'd3,
        READ       = 3'd4,
        READ_WAIT  = 3'd5,
        TX_RDATA   = 3'd6
    } ssp_state_e;

endpackage

// File: rtl/slave_serial_port_serial_shift_reg.sv
// LSB-first shift register with parallel load; exposes the value it will hold after this edge.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] next_c
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = pdata;
        end else if (shift) begin
            data_d = {sin, data_q[WIDTH-1:1]};
        end
    end

    assign next_c = data_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/slave_serial_port.sv
// Serial-to-memory slave port: deserialises address/burst/write data, serialises read data.
module slave_serial_port
    import slave_serial_port_pkg::*;
#(
    parameter int unsigned ADDR_LEN  = SSP_ADDR_LEN,
    parameter int unsigned DATA_LEN  = SSP_DATA_LEN,
    parameter int unsigned BURST_LEN = SSP_BURST_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_en,
    input  logic                write_en,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                rx_address,
    input  logic                rx_burst,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    localparam int unsigned MAX_LEN = (ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    ssp_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BURST_LEN-1:0]  beats_q, beats_d;
    logic [ADDR_LEN-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  slave_ready_q, slave_ready_d;
    logic                  slave_valid_q, slave_valid_d;
    logic                  tx_data_q, tx_data_d;

    logic                  addr_shift, burst_shift, wdata_shift, rdata_load, rdata_shift;
    logic [ADDR_LEN-1:0]   addr_next;
    logic [BURST_LEN-1:0]  burst_next;
    logic [DATA_LEN-1:0]   wdata_next;
    logic [DATA_LEN-1:0]   rdata_next;
    logic                  unused_rdata_hi;

    serial_shift_reg #(.WIDTH(ADDR_LEN)) u_addr_sr (
        .clk(clk), .rst(rst), .load(1'b0), .shift(addr_shift),
        .sin(rx_address), .pdata('0), .next_c(addr_next)
    );

    serial_shift_reg #(.WIDTH(BURST_LEN)) u_burst_sr (
        .clk(clk), .rst(rst), .load(1'b0), .shift(burst_shift),
        .sin(rx_burst), .pdata('0), .next_c(burst_next)
    );

    serial_shift_reg #(.WIDTH(DATA_LEN)) u_wdata_sr (
        .clk(clk), .rst(rst), .load(1'b0), .shift(wdata_shift),
        .sin(rx_data), .pdata('0), .next_c(wdata_next)
    );

    serial_shift_reg #(.WIDTH(DATA_LEN)) u_rdata_sr (
        .clk(clk), .rst(rst), .load(rdata_load), .shift(rdata_shift),
        .sin(1'b0), .pdata(mem_rdata), .next_c(rdata_next)
    );

    // Only the LSB of the read shifter leaves the block.
    assign unused_rdata_hi = ^rdata_next[DATA_LEN-1:1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_shift  = 1'b0;
        burst_shift = 1'b0;
        wdata_shift = 1'b0;
        rdata_load  = 1'b0;
        rdata_shift = 1'b0;

        // Dropping both enables abandons the transaction without touching memory.
        if (state_q != IDLE && !read_en && !write_en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((read_en ^ write_en) && master_valid) begin
                        addr_shift  = 1'b1;
                        burst_shift = 1'b1;
                        cnt_d       = CNT_W'(1);
                        state_d     = RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    if (master_valid) begin
                        addr_shift  = 1'b1;
                        burst_shift = (cnt_q < CNT_W'(BURST_LEN));
                        cnt_d       = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_LEN - 1)) begin
                            mem_addr_d = addr_next;
                            beats_d    = (burst_next == '0) ? BURST_LEN'(1) : burst_next;
                            cnt_d      = '0;
                            state_d    = write_en ? RX_WDATA : READ;
                        end
                    end
                end
                RX_WDATA: begin
                    if (master_valid) begin
                        wdata_shift = 1'b1;
                        cnt_d       = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
                            mem_wdata_d = wdata_next;
                            cnt_d       = '0;
                            state_d     = WRITE;
                        end
                    end
                end
                WRITE: begin
                    beats_d = beats_q - BURST_LEN'(1);
                    if (beats_q > BURST_LEN'(1)) begin
                        mem_addr_d = mem_addr_q + ADDR_LEN'(1);
                        state_d    = RX_WDATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                READ: begin
                    state_d = READ_WAIT;
                end
                READ_WAIT: begin
                    rdata_load = 1'b1;
                    cnt_d      = '0;
                    state_d    = TX_RDATA;
                end
                TX_RDATA: begin
                    if (master_ready) begin
                        rdata_shift = 1'b1;
                        cnt_d       = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
                            cnt_d   = '0;
                            beats_d = beats_q - BURST_LEN'(1);
                            if (beats_q > BURST_LEN'(1)) begin
                                mem_addr_d = mem_addr_q + ADDR_LEN'(1);
                                state_d    = READ;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered versions of what the next state presents.
        mem_we_d      = (state_d == WRITE);
        mem_re_d      = (state_d == READ);
        slave_ready_d = (state_d == IDLE) || (state_d == RX_ADDR) || (state_d == RX_WDATA);
        slave_valid_d = (state_d == TX_RDATA);
        tx_data_d     = slave_valid_d & rdata_next[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            beats_q       <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            slave_ready_q <= 1'b1;
            slave_valid_q <= 1'b0;
            tx_data_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            beats_q       <= beats_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            slave_ready_q <= slave_ready_d;
            slave_valid_q <= slave_valid_d;
            tx_data_q     <= tx_data_d;
        end
    end

    assign slave_ready = slave_ready_q;
    assign slave_valid = slave_valid_q;
    assign tx_data     = tx_data_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;

endmodule

// File: tb/tb_slave_serial_port.sv
// Bench for slave_serial_port: transaction-level model with queues of expected memory and tx events.
module tb_slave_serial_port;

    localparam int unsigned AL = 12;
    localparam int unsigned DL = 8;
    localparam int unsigned BL = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          read_en = 1'b0, write_en = 1'b0;
    logic          master_valid = 1'b0, master_ready = 1'b1;
    logic          rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
    logic          slave_ready, slave_valid, tx_data;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_we, mem_re;
    logic [DL-1:0] mem_rdata = '0;

    slave_serial_port #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AL-1:0] a;
        logic [DL-1:0] d;
    } wr_t;

    int            errors = 0;
    int            checks = 0;
    logic [DL-1:0] mem     [0:(1<<AL)-1];
    logic [DL-1:0] ref_mem [0:(1<<AL)-1];
    logic [DL-1:0] wbuf    [0:3];
    wr_t           exp_wr[$];
    logic [AL-1:0] exp_rd[$];
    logic          exp_tx[$];

    // Bench memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected events of a whole transaction, from address arithmetic and the reference memory.
    task automatic model_txn(input bit is_wr, input logic [AL-1:0] addr, input logic [BL-1:0] burst);
        int            n;
        logic [AL-1:0] a;
        wr_t           w;
        n = (burst == '0) ? 1 : int'(burst);
        for (int b = 0; b < n; b++) begin
            a = AL'(int'(addr) + b);
            if (is_wr) begin
                w.a = a;
                w.d = wbuf[b];
                exp_wr.push_back(w);
                ref_mem[a] = wbuf[b];
            end else begin
                exp_rd.push_back(a);
                for (int i = 0; i < int'(DL); i++) exp_tx.push_back(ref_mem[a][i]);
            end
        end
    endtask

    // Compare process: every strobe and every accepted tx bit against the model queues.
    always @(negedge clk) begin
        wr_t           w;
        logic [AL-1:0] ra;
        logic          tb;
        if (rst) begin
            if (mem_we || mem_re) check("strobe_exclusive", 32'(mem_we & mem_re), 32'(0));
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
                end else begin
                    w = exp_wr.pop_front();
                    check("mem_write", 32'({mem_addr, mem_wdata}), 32'(w));
                end
            end
            if (mem_re) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr 0x%0h, required no read", mem_addr);
                end else begin
                    ra = exp_rd.pop_front();
                    check("mem_read_addr", 32'(mem_addr), 32'(ra));
                end
            end
            if (slave_valid && master_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_bit: got %0b, required no bit", tx_data);
                end else begin
                    tb = exp_tx.pop_front();
                    check("tx_bit", 32'(tx_data), 32'(tb));
                end
            end
        end
    end

    task automatic drive_addr(input logic [AL-1:0] addr, input logic [BL-1:0] burst, input bit stall);
        for (int i = 0; i < int'(AL); i++) begin
            if (stall) begin
                master_valid = 1'b0;
                rx_address   = ~addr[i];
                rx_burst     = ~rx_burst;
                step();
            end
            master_valid = 1'b1;
            rx_address   = addr[i];
            rx_burst     = (i < int'(BL)) ? burst[i] : 1'b0;
            step();
        end
        master_valid = 1'b0;
    endtask

    task automatic drive_wdata(input int n);
        int guard;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < int'(DL); i++) begin
                guard = 0;
                while (!slave_ready && guard < 20) begin
                    master_valid = 1'b0;
                    step();
                    guard++;
                end
                if (!slave_ready) begin
                    checks++; errors++;
                    $display("FAIL wdata_ready_timeout: slave_ready=%0b, required 1", slave_ready);
                end
                master_valid = 1'b1;
                rx_data      = wbuf[b][i];
                step();
            end
        end
        master_valid = 1'b0;
    endtask

    task automatic drive_rx(input int n, input bit tx_stall);
        int acc = 0, hold = 0, guard = 0;
        while (acc < n * int'(DL) && guard < 2000) begin
            if (tx_stall && acc == 4 && hold < 3) begin
                master_ready = 1'b0;
                hold++;
            end else begin
                master_ready = 1'b1;
            end
            if (slave_valid && master_ready) acc++;
            step();
            guard++;
        end
        master_ready = 1'b1;
        if (acc != n * int'(DL)) check("rx_bits_timeout", 32'(acc), 32'(n * int'(DL)));
    endtask

    task automatic wait_drained(input string name);
        int guard = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && guard < 200) begin
            step();
            guard++;
        end
        check(name, 32'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 32'(0));
    endtask

    task automatic finish_txn(input string name);
        check({name, "_idle_ready"}, 32'(slave_ready), 32'(1));
        check({name, "_idle_valid"}, 32'(slave_valid), 32'(0));
        read_en  = 1'b0;
        write_en = 1'b0;
        step();
    endtask

    task automatic run_txn(input string name, input bit is_wr, input logic [AL-1:0] addr,
                           input logic [BL-1:0] burst, input bit addr_stall, input bit tx_stall);
        int n;
        n = (burst == '0) ? 1 : int'(burst);
        write_en = is_wr;
        read_en  = !is_wr;
        drive_addr(addr, burst, addr_stall);
        if (is_wr) drive_wdata(n);
        else       drive_rx(n, tx_stall);
        wait_drained({name, "_drained"});
        finish_txn(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DL-1:0] byte_v;
        int            re_cnt;

        for (int i = 0; i < (1 << AL); i++) begin
            mem[i]     = DL'(i * 37 + 5);
            ref_mem[i] = DL'(i * 37 + 5);
        end
        mem[12'h010] = 8'h11; ref_mem[12'h010] = 8'h11;
        mem[12'h011] = 8'h22; ref_mem[12'h011] = 8'h22;
        mem[12'h012] = 8'h33; ref_mem[12'h012] = 8'h33;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_slave_ready", 32'(slave_ready), 32'(1));
        check("rst_slave_valid", 32'(slave_valid), 32'(0));
        check("rst_tx_data",     32'(tx_data),     32'(0));
        check("rst_mem_we",      32'(mem_we),      32'(0));
        check("rst_mem_re",      32'(mem_re),      32'(0));
        check("rst_mem_addr",    32'(mem_addr),    32'(0));
        check("rst_mem_wdata",   32'(mem_wdata),   32'(0));
        rst = 1'b1;
        step();

        // Single write
        wbuf[0] = 8'hA5;
        model_txn(1'b1, 12'h123, 12'd1);
        check("pin_single_write", 32'(exp_wr[0]), 32'({12'h123, 8'hA5}));
        run_txn("single_write", 1'b1, 12'h123, 12'd1, 1'b0, 1'b0);

        // Burst read of three
        model_txn(1'b0, 12'h010, 12'd3);
        check("pin_read_addr_last", 32'(exp_rd[2]), 32'h012);
        for (int i = 0; i < 8; i++) byte_v[i] = exp_tx[8 + i];
        check("pin_read_byte1", 32'(byte_v), 32'h22);
        run_txn("burst_read", 1'b0, 12'h010, 12'd3, 1'b0, 1'b0);

        // Address wrap on a two-beat write, then read back across the wrap with tx stall
        wbuf[0] = 8'h3C;
        wbuf[1] = 8'hC3;
        model_txn(1'b1, 12'hFFF, 12'd2);
        check("pin_wrap_addr", 32'(exp_wr[1].a), 32'h000);
        run_txn("wrap_write", 1'b1, 12'hFFF, 12'd2, 1'b0, 1'b0);
        model_txn(1'b0, 12'hFFF, 12'd2);
        run_txn("wrap_read", 1'b0, 12'hFFF, 12'd2, 1'b0, 1'b1);

        // Stalls in the address phase and mid-byte on tx
        model_txn(1'b0, 12'h5A7, 12'd1);
        run_txn("stall_read", 1'b0, 12'h5A7, 12'd1, 1'b1, 1'b1);

        // Burst field of zero is one beat
        wbuf[0] = 8'h5E;
        model_txn(1'b1, 12'h400, 12'd0);
        check("pin_burst0_beats", 32'(exp_wr.size()), 32'(1));
        run_txn("burst0_write", 1'b1, 12'h400, 12'd0, 1'b1, 1'b0);
        model_txn(1'b0, 12'h400, 12'd0);
        run_txn("burst0_read", 1'b0, 12'h400, 12'd0, 1'b0, 1'b0);

        // Both enables high: stay idle, no strobes
        read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1; rx_address = 1'b1; rx_burst = 1'b1; rx_data = 1'b1;
        repeat (25) begin
            step();
            check("illegal_ready", 32'(slave_ready), 32'(1));
            check("illegal_strobes", 32'(mem_we | mem_re | slave_valid), 32'(0));
        end
        read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
        step();

        // Abandon a write mid-data; the next transaction must start cleanly
        write_en = 1'b1;
        drive_addr(12'h055, 12'd1, 1'b0);
        master_valid = 1'b1;
        repeat (3) step();
        master_valid = 1'b0;
        write_en = 1'b0;
        repeat (3) step();
        check("abort_no_strobe_ready", 32'(slave_ready), 32'(1));
        wbuf[0] = 8'h81;
        wbuf[1] = 8'h7E;
        model_txn(1'b1, 12'h7FE, 12'd2);
        run_txn("after_abort_write", 1'b1, 12'h7FE, 12'd2, 1'b0, 1'b0);
        model_txn(1'b0, 12'h7FE, 12'd2);
        run_txn("after_abort_read", 1'b0, 12'h7FE, 12'd2, 1'b0, 1'b0);

        // Reset in the middle of a read burst
        exp_rd.push_back(12'h200);
        for (int i = 0; i < 3; i++) exp_tx.push_back(ref_mem[12'h200][i]);
        read_en = 1'b1;
        drive_addr(12'h200, 12'd3, 1'b0);
        begin
            int acc = 0, guard = 0;
            while (acc < 3 && guard < 50) begin
                if (slave_valid && master_ready) acc++;
                step();
                guard++;
            end
            check("rst_mid_bits", 32'(acc), 32'(3));
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_valid",    32'(slave_valid), 32'(0));
        check("rst_mid_ready",    32'(slave_ready), 32'(1));
        check("rst_mid_re",       32'(mem_re),      32'(0));
        check("rst_mid_addr",     32'(mem_addr),    32'(0));
        check("rst_mid_read_seen", 32'(exp_rd.size()), 32'(0));
        exp_tx.delete();
        read_en = 1'b0;
        step();
        step();
        rst = 1'b1;
        re_cnt = 0;
        repeat (10) begin
            step();
            if (mem_re) re_cnt++;
        end
        check("rst_mid_no_more_reads", 32'(re_cnt), 32'(0));

        // Normal operation after reset
        model_txn(1'b0, 12'h011, 12'd1);
        run_txn("post_reset_read", 1'b0, 12'h011, 12'd1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
